key_event_debounce_n: RTL and testbench
=======================================

# key_event_debounce_n

Parametrised, multi-channel key-event generator. It replaces the single-channel press-pulse debouncer. Each of `N_KEYS` raw key/button inputs is synchronised, then filtered with a lockout window on both edges, and produces single-cycle press, release and optional auto-repeat pulses. It sits between the raw board inputs or keypad scanner and the downstream control FSMs, which consume one-cycle event strobes.

## Interface
- `N_KEYS`, 4: number of independent channels (≥1).
- `LOCKOUT_CYCLES`, 6_000_000: cycles during which a channel ignores its input after any accepted edge (≥1).
- `REPEAT_DELAY`, 30_000_000: cycles a key must stay in HELD before the first repeat (≥1).
- `REPEAT_PERIOD`, 6_000_000: cycles between subsequent repeats (≥1).
- `CNT_W`, 26: counter width. Must hold max(LOCKOUT_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).
- `clk` in 1: single system clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `key_in` in N_KEYS: raw asynchronous key levels; 1 = pressed.
- `repeat_en` in 1: global auto-repeat enable.
- `press_evt` out N_KEYS: one-cycle pulse per accepted press.
- `release_evt` out N_KEYS: one-cycle pulse per accepted release.
- `repeat_evt` out N_KEYS: one-cycle pulse per auto-repeat.
- `key_state` out N_KEYS: debounced level, 1 from the press pulse until the release pulse.
- `any_evt` out 1: registered OR of all three event vectors, aligned with them.

## Operation
- Each channel has a 2-flop synchroniser (`s1`, `s2`), an FSM, a `CNT_W`-bit counter and a `first` flag. Channels are fully independent and there is no shared arbitration.
- FSM states:
  - IDLE: if `s2`=1, pulse `press_evt`, set `key_state`=1, set cnt=0 and go to LOCK_P.
  - LOCK_P: `s2` is ignored and cnt increments each cycle. At cnt=LOCKOUT_CYCLES-1, go to HELD with cnt=0 and `first`=1.
  - HELD, in priority order:
    - If `s2`=0: pulse `release_evt`, set `key_state`=0, set cnt=0 and go to LOCK_R.
    - Else if `repeat_en`=1: increment cnt. When cnt reaches (`first` ? REPEAT_DELAY : REPEAT_PERIOD)-1, pulse `repeat_evt`, set cnt=0 and `first`=0.
    - Else (`repeat_en`=0): hold cnt=0 and `first`=1.
  - LOCK_R: `s2` is ignored and cnt increments. At cnt=LOCKOUT_CYCLES-1, go to IDLE.
- Release in HELD has priority over a repeat due in the same cycle, so no repeat is issued that cycle.
- Deasserting `repeat_en` mid-hold stops repeats immediately. Re-asserting it restarts the full REPEAT_DELAY.
- A release that happens during LOCK_P is detected on the first HELD cycle. A press that happens during LOCK_R is detected on the first IDLE cycle.
- Per channel, at most one of `press_evt`, `release_evt` and `repeat_evt` is high in any cycle.
- Counters never wrap. Each counter is cleared on every state change.

## Timing
- Reset (`rst`=1 at an edge):
  - all FSMs go to IDLE;
  - cnt=0, `first`=1, `s1`=`s2`=0;
  - all outputs go to 0 on the next cycle.
- Reset applied mid-operation aborts the lockout or hold without emitting any event.
- A key held through reset deassertion produces `press_evt` 2 cycles after `rst` falls, because of the synchroniser.
- Latency: if `key_in` is first sampled high at edge k, `s2`=1 after edge k+1. `press_evt` and `key_state` are then registered at edge k+2, giving a 2-cycle latency. Release uses the same latency when the channel is in HELD.
- Pulse width: every event is high for exactly 1 cycle, and `any_evt` is in the same cycle.
- Minimum spacing between a press and the following release on one channel is LOCKOUT_CYCLES+1 cycles. The same applies between a release and the following press.
- First repeat: REPEAT_DELAY cycles after entering HELD, i.e. LOCKOUT_CYCLES+REPEAT_DELAY cycles after `press_evt`. Later repeats occur every REPEAT_PERIOD cycles.

## Test plan
Use N_KEYS=4, LOCKOUT_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3 and CNT_W=8.
1. Clean press on key0 at edge 10 with `repeat_en`=0, held for 30 cycles, then released → `press_evt[0]` at edge 12 only. `key_state[0]` goes 1 at edge 12 and returns to 0 two edges after release, together with a single `release_evt[0]`. There is no `repeat_evt`.
2. Bounce on key1 (toggling every cycle for 3 cycles after the first rise, then stable high) → exactly 1 `press_evt[1]` and no `release_evt`. The bounce after lockout expiry is handled the same way: a level still stable-high produces nothing.
3. Auto-repeat: `repeat_en`=1 and key2 held for 40 cycles → `repeat_evt[2]` at press+14, +17, +20 and so on. Release arriving on a repeat-due cycle gives `release_evt` only.
4. Simultaneous press on all 4 keys in the same cycle → all 4 `press_evt` bits high in the same cycle, and `any_evt`=1 for exactly 1 cycle.
5. Reset: assert `rst` in LOCK_P with key3 held, deassert it after 2 cycles with key3 still held → no `release_evt`. Outputs are 0 during reset, and a fresh `press_evt[3]` occurs 2 cycles after `rst` falls.
6. Short tap: a 1-cycle high on key0 → `press_evt` fires, then `release_evt` on the first HELD cycle, exactly LOCKOUT_CYCLES+1 cycles later.

Source files
------------

// File: rtl/key_event_debounce_n.sv
// -----------------------------------------------------------------------------
// key_event_debounce_n
//
// Multi-channel key event generator. Every raw key level is brought into the
// clock domain through a two-flop synchroniser, then run through a small FSM
// that accepts an edge, locks the channel out for a fixed number of cycles so
// contact bounce is ignored, and emits one-cycle press, release and optional
// auto-repeat strobes. Channels share nothing except the clock, the reset and
// the global repeat enable.
//
// Ports
//    clk          system clock, everything on the rising edge
//    rst          synchronous active-high reset
//    key_in       raw asynchronous key levels, 1 = pressed
//    repeat_en    global auto-repeat enable
//    press_evt    one-cycle strobe per accepted press
//    release_evt  one-cycle strobe per accepted release
//    repeat_evt   one-cycle strobe per auto-repeat
//    key_state    debounced level, set by the press strobe, cleared by release
//    any_evt      registered OR of all event strobes, same cycle as them
// -----------------------------------------------------------------------------
module key_event_debounce_n #(
   parameter int N_KEYS         = 4,
   parameter int LOCKOUT_CYCLES = 6_000_000,
   parameter int REPEAT_DELAY   = 30_000_000,
   parameter int REPEAT_PERIOD  = 6_000_000,
   parameter int CNT_W          = 26
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_in,
   input  logic              repeat_en,
   output logic [N_KEYS-1:0] press_evt,
   output logic [N_KEYS-1:0] release_evt,
   output logic [N_KEYS-1:0] repeat_evt,
   output logic [N_KEYS-1:0] key_state,
   output logic              any_evt
);

   typedef enum logic [1:0] {
      IDLE,
      LOCK_P,
      HELD,
      LOCK_R
   } keyState_t;

   // Terminal counts: counters start at 0, so the last cycle of an N-cycle
   // window is N-1.
   localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCKOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

   // Per-channel "an event fires on this edge" conditions. They drive both the
   // channel FSM and the shared any_evt register, which keeps any_evt aligned
   // with the individual strobes without a second pipeline stage.
   logic [N_KEYS-1:0] w_pressFire;
   logic [N_KEYS-1:0] w_releaseFire;
   logic [N_KEYS-1:0] w_repeatFire;

   for (genvar g = 0; g < N_KEYS; g++) begin : gChannel
      keyState_t        r_state;
      logic [CNT_W-1:0] r_cnt;
      logic             r_first;
      logic             r_sync1;
      logic             r_sync2;
      logic             r_press;
      logic             r_release;
      logic             r_repeat;
      logic             r_level;
      logic [CNT_W-1:0] w_repeatLast;

      // The first repeat waits the long delay, later ones the short period.
      assign w_repeatLast = r_first ? DELAY_LAST : PERIOD_LAST;

      // Release outranks repeat in HELD, so the repeat condition requires the
      // synchronised key to still be high.
      assign w_pressFire[g]   = (r_state == IDLE) && r_sync2;
      assign w_releaseFire[g] = (r_state == HELD) && !r_sync2;
      assign w_repeatFire[g]  = (r_state == HELD) && r_sync2 && repeat_en &&
                                (r_cnt == w_repeatLast);

      // Synchroniser plus channel FSM. Event strobes default low every cycle so
      // each one lasts exactly one clock. The counter is cleared on every state
      // change and only ever counts up to a terminal value, so it never wraps.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_first   <= 1'b1;
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
            r_level   <= 1'b0;
         end else begin
            r_sync1   <= key_in[g];
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
            case (r_state)
               IDLE: begin
                  if (w_pressFire[g]) begin
                     r_press <= 1'b1;
                     r_level <= 1'b1;
                     r_cnt   <= '0;
                     r_state <= LOCK_P;
                  end
               end
               LOCK_P: begin
                  if (r_cnt == LOCK_LAST) begin
                     r_cnt   <= '0;
                     r_first <= 1'b1;
                     r_state <= HELD;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               HELD: begin
                  if (w_releaseFire[g]) begin
                     r_release <= 1'b1;
                     r_level   <= 1'b0;
                     r_cnt     <= '0;
                     r_state   <= LOCK_R;
                  end else if (repeat_en) begin
                     if (w_repeatFire[g]) begin
                        r_repeat <= 1'b1;
                        r_cnt    <= '0;
                        r_first  <= 1'b0;
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end else begin
                     // Repeat disabled: park the timer so re-enabling starts
                     // the full initial delay again.
                     r_cnt   <= '0;
                     r_first <= 1'b1;
                  end
               end
               LOCK_R: begin
                  if (r_cnt == LOCK_LAST) begin
                     r_cnt   <= '0;
                     r_state <= IDLE;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               default: begin
                  r_cnt   <= '0;
                  r_state <= IDLE;
               end
            endcase
         end
      end

      assign press_evt[g]   = r_press;
      assign release_evt[g] = r_release;
      assign repeat_evt[g]  = r_repeat;
      assign key_state[g]   = r_level;
   end

   // Summary strobe, registered from the same fire conditions as the channel
   // strobes so it rises and falls in the same cycle as them.
   always_ff @(posedge clk) begin
      if (rst) begin
         any_evt <= 1'b0;
      end else begin
         any_evt <= |(w_pressFire | w_releaseFire | w_repeatFire);
      end
   end

endmodule

// File: tb/tb_key_event_debounce_n.sv
// -----------------------------------------------------------------------------
// tb_key_event_debounce_n
//
// Drives directed scenarios followed by a long randomised run into a 4-channel
// instance and compares every output after every clock edge against a
// timestamp-based reference model of key events.
// -----------------------------------------------------------------------------
module tb_key_event_debounce_n;

   localparam int NK = 4;
   localparam int LK = 4;
   localparam int RD = 10;
   localparam int RP = 3;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NK-1:0] key_in = '0;
   logic          repeat_en = 1'b0;
   logic [NK-1:0] press_evt;
   logic [NK-1:0] release_evt;
   logic [NK-1:0] repeat_evt;
   logic [NK-1:0] key_state;
   logic          any_evt;

   int checks   = 0;
   int failures = 0;
   int cycle    = 0;

   // Reference model state: debounced level, last edge index of the current
   // lockout, start time of the current repeat timing and first-repeat flag.
   int            mLevel     [NK];
   int            mLockUntil [NK];
   int            mArmTime   [NK];
   int            mFirst     [NK];
   logic [NK-1:0] mSync1 = '0;
   logic [NK-1:0] mSync2 = '0;
   logic [NK-1:0] expPress   = '0;
   logic [NK-1:0] expRelease = '0;
   logic [NK-1:0] expRepeat  = '0;
   logic [NK-1:0] expState   = '0;
   logic          expAny     = 1'b0;

   key_event_debounce_n #(
      .N_KEYS         (NK),
      .LOCKOUT_CYCLES (LK),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP),
      .CNT_W          (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_in      (key_in),
      .repeat_en   (repeat_en),
      .press_evt   (press_evt),
      .release_evt (release_evt),
      .repeat_evt  (repeat_evt),
      .key_state   (key_state),
      .any_evt     (any_evt)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Counts one comparison and reports it if the observed value is wrong.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h",
                  tag, cycle, observed, expected);
      end
   endtask

   // Sets the model back to its power-on view of the world.
   task automatic resetModel();
      for (int i = 0; i < NK; i++) begin
         mLevel[i]     = 0;
         mLockUntil[i] = -1;
         mArmTime[i]   = 0;
         mFirst[i]     = 1;
      end
      mSync1 = '0;
      mSync2 = '0;
   endtask

   // One clock edge of the model. An edge is accepted once the edge index is
   // past the lockout window; a held key repeats when the edge index reaches
   // the arming time plus the delay (first) or the period (later ones).
   task automatic modelStep(input logic rstV, input logic [NK-1:0] keyV,
                            input logic repV);
      expPress   = '0;
      expRelease = '0;
      expRepeat  = '0;
      if (rstV) begin
         resetModel();
      end else begin
         for (int i = 0; i < NK; i++) begin
            if (cycle > mLockUntil[i] && int'(mSync2[i]) != mLevel[i]) begin
               if (mSync2[i]) begin
                  expPress[i] = 1'b1;
                  mLevel[i]   = 1;
                  mArmTime[i] = cycle + LK;
                  mFirst[i]   = 1;
               end else begin
                  expRelease[i] = 1'b1;
                  mLevel[i]     = 0;
               end
               mLockUntil[i] = cycle + LK;
            end else if (cycle > mLockUntil[i] && mLevel[i] == 1) begin
               if (!repV) begin
                  mArmTime[i] = cycle;
                  mFirst[i]   = 1;
               end else if (cycle == mArmTime[i] + ((mFirst[i] == 1) ? RD : RP)) begin
                  expRepeat[i] = 1'b1;
                  mArmTime[i]  = cycle;
                  mFirst[i]    = 0;
               end
            end
         end
         mSync2 = mSync1;
         mSync1 = keyV;
      end
      for (int i = 0; i < NK; i++) begin
         expState[i] = (mLevel[i] == 1);
      end
      expAny = |(expPress | expRelease | expRepeat);
   endtask

   // Drives one cycle of inputs on the falling edge, advances the model on the
   // rising edge and compares all outputs shortly after it.
   task automatic applyStimulus(input logic rstV, input logic [NK-1:0] keyV,
                                input logic repV);
      @(negedge clk);
      rst       = rstV;
      key_in    = keyV;
      repeat_en = repV;
      @(posedge clk);
      modelStep(rstV, keyV, repV);
      cycle++;
      #1;
      checkOutput("press_evt",   32'(press_evt),   32'(expPress));
      checkOutput("release_evt", 32'(release_evt), 32'(expRelease));
      checkOutput("repeat_evt",  32'(repeat_evt),  32'(expRepeat));
      checkOutput("key_state",   32'(key_state),   32'(expState));
      checkOutput("any_evt",     32'(any_evt),     32'(expAny));
   endtask

   initial begin : mainSequence
      logic [NK-1:0] randKeys;
      logic          randRep;
      resetModel();

      // Reset state.
      repeat (3) applyStimulus(1'b1, 4'b0000, 1'b0);

      // Clean press on key0, no repeat, held 30 cycles.
      repeat (5)  applyStimulus(1'b0, 4'b0000, 1'b0);
      repeat (30) applyStimulus(1'b0, 4'b0001, 1'b0);
      repeat (10) applyStimulus(1'b0, 4'b0000, 1'b0);

      // Bounce on key1 then stable high.
      applyStimulus(1'b0, 4'b0010, 1'b0);
      applyStimulus(1'b0, 4'b0000, 1'b0);
      applyStimulus(1'b0, 4'b0010, 1'b0);
      applyStimulus(1'b0, 4'b0000, 1'b0);
      repeat (20) applyStimulus(1'b0, 4'b0010, 1'b0);
      repeat (10) applyStimulus(1'b0, 4'b0000, 1'b0);

      // Auto-repeat on key2; the release lands on a repeat-due edge.
      repeat (41) applyStimulus(1'b0, 4'b0100, 1'b1);
      repeat (10) applyStimulus(1'b0, 4'b0000, 1'b1);

      // All keys pressed together.
      repeat (8)  applyStimulus(1'b0, 4'b1111, 1'b0);
      repeat (10) applyStimulus(1'b0, 4'b0000, 1'b0);

      // Reset during the press lockout of key3, key held throughout.
      repeat (3)  applyStimulus(1'b0, 4'b1000, 1'b0);
      repeat (2)  applyStimulus(1'b1, 4'b1000, 1'b0);
      repeat (12) applyStimulus(1'b0, 4'b1000, 1'b0);
      repeat (10) applyStimulus(1'b0, 4'b0000, 1'b0);

      // Single-cycle tap on key0.
      applyStimulus(1'b0, 4'b0001, 1'b0);
      repeat (12) applyStimulus(1'b0, 4'b0000, 1'b0);

      // Randomised run: keys flip occasionally, repeat enable toggles rarely
      // and reset strikes very rarely.
      randKeys = '0;
      randRep  = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NK; i++) begin
            if ($urandom_range(0, 7) == 0) randKeys[i] = ~randKeys[i];
         end
         if ($urandom_range(0, 39) == 0) randRep = ~randRep;
         applyStimulus(($urandom_range(0, 299) == 0), randKeys, randRep);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
